// File: rtl/led_pkg.sv
// Shared definitions for the LED frame sequencer and the doled serialiser:
// item type codes, sequencer FSM states, frame phases and the colour scaler.
package led_pkg;

  localparam logic [1:0] TYPE_START = 2'd0;
  localparam logic [1:0] TYPE_LED   = 2'd1;
  localparam logic [1:0] TYPE_END   = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_SCALE     = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT_ACK  = 3'd4,
    ST_WAIT_DONE = 3'd5,
    ST_NEXT      = 3'd6,
    ST_FINISH    = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    PH_START = 2'd0,
    PH_LED   = 2'd1,
    PH_END   = 2'd2
  } phase_t;

  // (c * (b + 1)) >> 8: b = 255 passes c through, b = 0 blanks it.
  function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'(c) * (16'(b) + 16'd1);
    return prod[15:8];
  endfunction

endpackage

// File: rtl/led_frame_ram.sv
// Frame colour store: one write port, one read port, read-first, 1-cycle read.
module led_frame_ram #(
  parameter int NUM_LEDS = 60,
  parameter int AW       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [23:0]   wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [23:0]   rd_data_o
);

  logic [23:0] mem [NUM_LEDS];

  // Writes past the strip length are dropped; a read racing a write sees old data.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && (32'(wr_addr_i) < NUM_LEDS)) begin
      mem[wr_addr_i] <= wr_data_i;
    end
    rd_data_o <= mem[rd_addr_i];
  end

endmodule

// File: rtl/led_frame_sequencer.sv
// Walks the frame RAM on frame_go and feeds doled one START, NUM_LEDS LED
// and END_FRAMES END items. Handshake: doled_start is held high with colour/type
// stable until doled_busy is seen high, then dropped; the next item is only
// offered after doled_busy has been seen low again.
module led_frame_sequencer
  import led_pkg::*;
#(
  parameter int NUM_LEDS    = 60,
  parameter int END_FRAMES  = 1,
  parameter int ACK_TIMEOUT = 255,
  parameter int AW          = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic          ledseq_clk,
  input  logic          ledseq_rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_data,
  input  logic [7:0]    brightness,
  input  logic          frame_go,
  output logic          frame_busy,
  output logic          frame_done,
  output logic          frame_error,
  output logic [7:0]    red_out,
  output logic [7:0]    green_out,
  output logic [7:0]    blue_out,
  output logic [1:0]    type_out,
  output logic          doled_start,
  input  logic          doled_busy,
  output logic [2:0]    dbg_state
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam int EW = (END_FRAMES > 1) ? $clog2(END_FRAMES) : 1;

  state_t        state_q;
  phase_t        phase_q;
  logic [AW-1:0] idx_q;
  logic [EW-1:0] end_cnt_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    bright_q;
  logic [23:0]   rd_data;

  led_frame_ram #(.NUM_LEDS(NUM_LEDS), .AW(AW)) u_ram (
    .clk_i     (ledseq_clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (idx_q),
    .rd_data_o (rd_data)
  );

  assign dbg_state = state_q;

  // Every transition into ISSUE loads the item and raises doled_start on the same edge.
  always_ff @(posedge ledseq_clk or negedge ledseq_rst_n) begin
    if (!ledseq_rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= PH_START;
      idx_q       <= '0;
      end_cnt_q   <= '0;
      cnt_q       <= '0;
      bright_q    <= '0;
      frame_busy  <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      red_out     <= '0;
      green_out   <= '0;
      blue_out    <= '0;
      type_out    <= TYPE_START;
      doled_start <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (frame_go && !frame_busy) begin
            bright_q    <= brightness;
            frame_error <= 1'b0;
            frame_busy  <= 1'b1;
            phase_q     <= PH_START;
            idx_q       <= '0;
            end_cnt_q   <= '0;
            red_out     <= '0;
            green_out   <= '0;
            blue_out    <= '0;
            type_out    <= TYPE_START;
            doled_start <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_FETCH: state_q <= ST_SCALE;
        ST_SCALE: begin
          red_out     <= scale_ch(rd_data[23:16], bright_q);
          green_out   <= scale_ch(rd_data[15:8], bright_q);
          blue_out    <= scale_ch(rd_data[7:0], bright_q);
          type_out    <= TYPE_LED;
          doled_start <= 1'b1;
          state_q     <= ST_ISSUE;
        end
        ST_ISSUE: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (doled_busy) begin
            doled_start <= 1'b0;
            state_q     <= ST_WAIT_DONE;
          end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
            doled_start <= 1'b0;
            frame_error <= 1'b1;
            frame_busy  <= 1'b0;
            frame_done  <= 1'b1;
            state_q     <= ST_FINISH;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!doled_busy) state_q <= ST_NEXT;
        end
        ST_NEXT: begin
          case (phase_q)
            PH_START: begin
              phase_q <= PH_LED;
              idx_q   <= '0;
              state_q <= ST_FETCH;
            end
            PH_LED: begin
              if (idx_q == AW'(NUM_LEDS - 1)) begin
                phase_q     <= PH_END;
                end_cnt_q   <= '0;
                red_out     <= '0;
                green_out   <= '0;
                blue_out    <= '0;
                type_out    <= TYPE_END;
                doled_start <= 1'b1;
                state_q     <= ST_ISSUE;
              end else begin
                idx_q   <= idx_q + 1'b1;
                state_q <= ST_FETCH;
              end
            end
            default: begin
              if (end_cnt_q == EW'(END_FRAMES - 1)) begin
                frame_busy <= 1'b0;
                frame_done <= 1'b1;
                state_q    <= ST_FINISH;
              end else begin
                end_cnt_q   <= end_cnt_q + 1'b1;
                doled_start <= 1'b1;
                state_q     <= ST_ISSUE;
              end
            end
          endcase
        end
        ST_FINISH: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Directed-plus-random bench for led_frame_sequencer with a doled-like BFM and
// an item-level reference model of each frame.
module tb_led_frame_sequencer;

  localparam int NUM_LEDS    = 3;
  localparam int END_FRAMES  = 1;
  localparam int ACK_TIMEOUT = 10;
  localparam int AW          = 2;
  localparam int BUSY_CYCLES = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [23:0]   wr_data = '0;
  logic [7:0]    brightness = '0;
  logic          frame_go = 1'b0;
  logic          frame_busy, frame_done, frame_error;
  logic [7:0]    red_out, green_out, blue_out;
  logic [1:0]    type_out;
  logic          doled_start;
  logic          doled_busy = 1'b0;
  logic [2:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int start_hi = 0;
  bit bfm_dead = 1'b0;

  logic [23:0] shadow [NUM_LEDS];
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  led_frame_sequencer #(
    .NUM_LEDS(NUM_LEDS), .END_FRAMES(END_FRAMES), .ACK_TIMEOUT(ACK_TIMEOUT), .AW(AW)
  ) dut (
    .ledseq_clk   (clk),
    .ledseq_rst_n (rst_n),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .brightness   (brightness),
    .frame_go     (frame_go),
    .frame_busy   (frame_busy),
    .frame_done   (frame_done),
    .frame_error  (frame_error),
    .red_out      (red_out),
    .green_out    (green_out),
    .blue_out     (blue_out),
    .type_out     (type_out),
    .doled_start  (doled_start),
    .doled_busy   (doled_busy),
    .dbg_state    (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // doled BFM: accepts an item when idle and start is high, then stays busy.
  initial begin
    int  bcnt;
    bit  prev_start;
    bcnt = 0;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (doled_start && !prev_start) check("start_rise_while_busy", 32'(doled_busy), 32'd0);
      prev_start = doled_start;
      if (frame_done) begin
        done_cnt++;
        check("done_with_busy_low", 32'(frame_busy), 32'd0);
      end
      if (doled_start) start_hi++;
      if (!rst_n) begin
        doled_busy = 1'b0;
        bcnt = 0;
      end else if (doled_busy) begin
        bcnt--;
        if (bcnt == 0) doled_busy = 1'b0;
      end else if (doled_start && !bfm_dead) begin
        obs_q.push_back({6'd0, type_out, red_out, green_out, blue_out});
        doled_busy = 1'b1;
        bcnt = BUSY_CYCLES;
      end
    end
  end

  function automatic logic [7:0] ref_scale(input int c, input int b);
    return 8'((c * (b + 1)) / 256);
  endfunction

  task automatic build_exp(input int b);
    exp_q.push_back({6'd0, 2'd0, 24'h000000});
    for (int i = 0; i < NUM_LEDS; i++) begin
      exp_q.push_back({6'd0, 2'd1, ref_scale(int'(shadow[i][23:16]), b),
                       ref_scale(int'(shadow[i][15:8]), b), ref_scale(int'(shadow[i][7:0]), b)});
    end
    for (int i = 0; i < END_FRAMES; i++) exp_q.push_back({6'd0, 2'd2, 24'h000000});
  endtask

  task automatic compare_items(input string tag);
    check({tag, "_item_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      check({tag, "_item"}, obs_q.pop_front(), exp_q.pop_front());
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic write_led(input int a, input logic [23:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (a < NUM_LEDS) shadow[a] = d;
  endtask

  // Raises frame_go for one edge and checks the state one edge after acceptance.
  task automatic start_frame(input logic [7:0] b);
    @(negedge clk);
    brightness = b;
    frame_go = 1'b1;
    @(negedge clk);
    frame_go = 1'b0;
    brightness = 8'($urandom);
    @(posedge clk);
    #1;
    check("accept_busy", 32'(frame_busy), 32'd1);
    check("accept_start", 32'(doled_start), 32'd1);
    check("accept_type_colour", {6'd0, type_out, red_out, green_out, blue_out}, 32'd0);
    check("accept_error_clear", 32'(frame_error), 32'd0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] b);
    build_exp(int'(b));
    start_frame(b);
    wait_done(tag, 500);
    @(negedge clk);
    check({tag, "_error"}, 32'(frame_error), 32'd0);
    compare_items(tag);
  endtask

  initial begin
    int n;
    int fetches;
    int d0;

    // reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {20'd0, doled_start, frame_busy, frame_done, frame_error,
                            type_out, 6'd0}, 32'd0);
    check("reset_colours", {8'd0, red_out, green_out, blue_out}, 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;

    // primary colours at full brightness; out-of-range write must be dropped
    write_led(0, 24'hFF0000);
    write_led(1, 24'h00FF00);
    write_led(2, 24'h0000FF);
    write_led(3, 24'hABCDEF);
    run_frame("primaries", 8'd255);

    // scaling corners
    write_led(0, 24'h80FF01);
    run_frame("bright127", 8'd127);
    run_frame("bright0", 8'd0);

    // randomized contents and brightness
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < NUM_LEDS; i++) write_led(i, 24'($urandom));
      run_frame("random", 8'($urandom_range(0, 255)));
    end

    // ack timeout: doled never answers
    bfm_dead = 1'b1;
    start_hi = 0;
    start_frame(8'd200);
    wait_done("timeout", 200);
    @(negedge clk);
    check("timeout_start_cycles", 32'(start_hi), 32'(ACK_TIMEOUT + 1));
    check("timeout_error", 32'(frame_error), 32'd1);
    check("timeout_busy", 32'(frame_busy), 32'd0);
    check("timeout_items", 32'(obs_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    check("timeout_error_sticky", 32'(frame_error), 32'd1);
    bfm_dead = 1'b0;
    run_frame("after_timeout", 8'd255);

    // host write to idx 1 on the same edge it is fetched: old data goes out
    build_exp(255);
    start_frame(8'd255);
    fetches = 0;
    n = 0;
    while (fetches < 2 && n < 200) begin
      @(negedge clk);
      n++;
      if (dbg_state == 3'd1) fetches++;
    end
    check("fetch_idx1_found", 32'(fetches), 32'd2);
    wr_en = 1'b1;
    wr_addr = 2'd1;
    wr_data = 24'h123456;
    @(negedge clk);
    wr_en = 1'b0;
    wait_done("rdfirst_old", 500);
    compare_items("rdfirst_old");
    shadow[1] = 24'h123456;
    run_frame("rdfirst_new", 8'd255);

    // frame_go held high: back-to-back frames, one per accept
    build_exp(90);
    build_exp(90);
    d0 = done_cnt;
    @(negedge clk);
    brightness = 8'd90;
    frame_go = 1'b1;
    n = 0;
    while (done_cnt == d0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("held_rearm_busy", 32'(frame_busy), 32'd1);
    frame_go = 1'b0;
    n = 0;
    while (done_cnt < d0 + 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    check("held_done_pulses", 32'(done_cnt - d0), 32'd2);
    check("held_idle", 32'(frame_busy), 32'd0);
    compare_items("held");

    // async reset in WAIT_DONE of LED 1
    start_frame(8'd255);
    n = 0;
    while (!(obs_q.size() == 3 && dbg_state == 3'd5) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reset_point_found", 32'(dbg_state), 32'd5);
    d0 = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", {20'd0, doled_start, frame_busy, frame_done, frame_error,
                               type_out, 6'd0}, 32'd0);
    check("midreset_colours", {8'd0, red_out, green_out, blue_out}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_no_done", 32'(done_cnt - d0), 32'd0);
    check("midreset_idle", 32'(dbg_state), 32'd0);
    obs_q.delete();
    exp_q.delete();
    run_frame("after_reset", 8'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
